// File: rtl/pb_press_detect.sv
// Debounced push-button event generator for an active-low pad input: press/release
// pulses, a held level, a one-shot long-press pulse and auto-repeat pulses.
module pb_press_detect #(
  parameter int unsigned DEBOUNCE_CYC = 65536,
  parameter int unsigned LONG_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_i,
  output logic pressed_o,
  output logic released_o,
  output logic held_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int unsigned HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_SAT    = DB_W'(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);
  localparam bit                DB_SINGLE = (DEBOUNCE_CYC == 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_REPEAT,
    ST_RELEASE_DB
  } state_e;

  logic              sync1_q, pb_s_q;
  state_e            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              pressed_q, pressed_d;
  logic              released_q, released_d;
  logic              held_q, held_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  logic [DB_W-1:0]   db_inc;
  logic [HOLD_W-1:0] hold_inc;
  logic              db_done, long_hit, rep_hit;

  // Counters saturate; "done" means the current sample is the last one needed.
  assign db_inc   = (db_cnt_q == DB_SAT) ? db_cnt_q : db_cnt_q + DB_ONE;
  assign hold_inc = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
  assign db_done  = (db_cnt_q >= DB_LAST);
  assign long_hit = (hold_cnt_q >= LONG_LAST);
  assign rep_hit  = (hold_cnt_q >= REP_LAST);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    pressed_d   = 1'b0;
    released_d  = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!pb_s_q) begin
          if (DB_SINGLE) begin
            state_d     = ST_HELD;
            pressed_d   = 1'b1;
            hold_cnt_d  = '0;
            long_flag_d = 1'b0;
          end else begin
            state_d  = ST_PRESS_DB;
            db_cnt_d = DB_ONE;
          end
        end
      end

      ST_PRESS_DB: begin
        if (pb_s_q) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d     = ST_HELD;
          pressed_d   = 1'b1;
          db_cnt_d    = '0;
          hold_cnt_d  = '0;
          long_flag_d = 1'b0;
        end else begin
          db_cnt_d = db_inc;
        end
      end

      ST_HELD, ST_REPEAT: begin
        hold_cnt_d = hold_inc;
        if (pb_s_q) begin
          // Remember where to resume if the release turns out to be bounce.
          long_flag_d = (state_q == ST_REPEAT);
          if (DB_SINGLE) begin
            state_d    = ST_IDLE;
            released_d = 1'b1;
          end else begin
            state_d  = ST_RELEASE_DB;
            db_cnt_d = DB_ONE;
          end
        end else if (state_q == ST_HELD && long_hit) begin
          long_d     = 1'b1;
          state_d    = ST_REPEAT;
          hold_cnt_d = '0;
        end else if (state_q == ST_REPEAT && rep_hit) begin
          repeat_d   = 1'b1;
          hold_cnt_d = '0;
        end
      end

      ST_RELEASE_DB: begin
        if (!pb_s_q) begin
          state_d  = long_flag_q ? ST_REPEAT : ST_HELD;
          db_cnt_d = '0;
        end else if (db_done) begin
          state_d    = ST_IDLE;
          released_d = 1'b1;
          db_cnt_d   = '0;
        end else begin
          db_cnt_d = db_inc;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    held_d = (state_d == ST_HELD) || (state_d == ST_REPEAT) || (state_d == ST_RELEASE_DB);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      pb_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
      held_q      <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync1_q     <= pb_i;
      pb_s_q      <= sync1_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      held_q      <= held_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign pressed_o    = pressed_q;
  assign released_o   = released_q;
  assign held_o       = held_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;

endmodule

// File: tb/tb_pb_press_detect.sv
// Bench for pb_press_detect: directed timing scenarios plus random button activity,
// all compared every cycle against a run-length reference model.
module tb_pb_press_detect;

  localparam int DB = 8;
  localparam int LC = 32;
  localparam int RC = 10;

  localparam logic [4:0] P  = 5'b10000;
  localparam logic [4:0] R  = 5'b01000;
  localparam logic [4:0] H  = 5'b00100;
  localparam logic [4:0] LG = 5'b00010;
  localparam logic [4:0] RP = 5'b00001;
  localparam logic [4:0] ALL = 5'b11111;

  logic clk;
  logic rst_n;
  logic pb, pb1;
  logic pressed, released, held, long_press, rep;
  logic pressed1, released1, held1, long_press1, rep1;
  logic [4:0] outs, outs1;

  int checks = 0;
  int errors = 0;

  assign outs  = {pressed, released, held, long_press, rep};
  assign outs1 = {pressed1, released1, held1, long_press1, rep1};

  pb_press_detect #(.DEBOUNCE_CYC(DB), .LONG_CYC(LC), .REPEAT_CYC(RC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_i         (pb),
    .pressed_o    (pressed),
    .released_o   (released),
    .held_o       (held),
    .long_press_o (long_press),
    .repeat_o     (rep)
  );

  pb_press_detect #(.DEBOUNCE_CYC(1), .LONG_CYC(4), .REPEAT_CYC(3)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb_i         (pb1),
    .pressed_o    (pressed1),
    .released_o   (released1),
    .held_o       (held1),
    .long_press_o (long_press1),
    .repeat_o     (rep1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the debounced level flips after DB consecutive opposite samples;
  // hold time accrues on every held cycle except those spent inside a release run.
  bit         m_s1 = 1'b1, m_s2 = 1'b1, m_deb = 1'b0, m_long_done = 1'b0, m_sample;
  int         m_run = 0, m_act = 0;
  logic [4:0] m_ev;
  logic [4:0] exp_q = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_deb = 1'b0; m_long_done = 1'b0;
      m_run = 0; m_act = 0; exp_q = '0;
    end else begin
      m_sample = m_s2;
      m_s2 = m_s1;
      m_s1 = pb;
      m_ev = '0;
      if (!m_deb) begin
        if (!m_sample) begin
          m_run++;
          if (m_run >= DB) begin
            m_deb = 1'b1; m_run = 0; m_act = 0; m_long_done = 1'b0; m_ev |= P;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (m_run == 0) m_act++;
        if (m_sample) begin
          m_run++;
          if (m_run >= DB) begin
            m_deb = 1'b0; m_run = 0; m_ev |= R;
          end
        end else begin
          if (m_run == 0 && m_act >= (m_long_done ? RC : LC)) begin
            m_ev |= m_long_done ? RP : LG;
            m_long_done = 1'b1;
            m_act = 0;
          end
          m_run = 0;
        end
      end
      exp_q = m_ev | (m_deb ? H : 5'b0);
    end
  end

  always @(negedge clk) begin
    checks++;
    assert (outs === exp_q) else begin
      errors++;
      $error("FAIL model observed=%b expected=%b t=%0t", outs, exp_q, $time);
    end
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_for(input int n, input logic [4:0] mask, input logic [4:0] val,
                            input string tag);
    repeat (n) begin
      step(1);
      check(tag, outs & mask, val);
    end
  endtask

  // Drive a press from idle; returns at the negedge just after the pressed edge.
  task automatic do_press();
    pb = 1'b0;
    expect_for(DB + 1, ALL, 5'b0, "press_wait");
    step(1);
    check("press_edge", outs, P | H);
  endtask

  task automatic do_release();
    pb = 1'b1;
    expect_for(DB + 1, ALL, H, "release_wait");
    step(1);
    check("release_edge", outs, R);
    step(1);
    check("release_after", outs, 5'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = 1'b1;
    pb1   = 1'b1;

    // Reset held while PB toggles, then a quiet idle period
    for (int i = 0; i < 20; i++) begin
      pb = 1'($urandom_range(0, 1));
      step(1);
      check("reset_quiet", outs, 5'b0);
    end
    pb = 1'b1;
    step(1);
    rst_n = 1'b1;
    expect_for(50, ALL, 5'b0, "idle");

    // Clean press, short hold, clean release
    do_press();
    step(1);
    check("press_one_cycle", outs, H);
    expect_for(17, ALL, H, "short_hold");
    do_release();
    step(5);

    // Press bounce: 7 low / 3 high three times, then stable low
    repeat (3) begin
      pb = 1'b0;
      expect_for(7, ALL, 5'b0, "bounce_low");
      pb = 1'b1;
      expect_for(3, ALL, 5'b0, "bounce_high");
    end
    do_press();
    do_release();
    step(5);

    // Long hold with repeats, then release and no further repeat
    do_press();
    expect_for(LC - 1, ALL, H, "long_wait");
    step(1);
    check("long_edge", outs, LG | H);
    for (int n = 1; n <= 4; n++) begin
      expect_for(RC - 1, ALL, H, "repeat_wait");
      step(1);
      check("repeat_edge", outs, RP | H);
    end
    expect_for(6, ALL, H, "hold_tail");
    do_release();
    expect_for(20, ALL, 5'b0, "after_release");

    // Release bounce delays the long press by the cycles spent debouncing
    do_press();
    expect_for(19, ALL, H, "rb_pre");
    pb = 1'b1;
    expect_for(5, ALL, H, "rb_glitch");
    pb = 1'b0;
    expect_for(12, ALL, H, "rb_hold");
    step(1);
    check("rb_long_edge", outs, LG | H);
    do_release();
    step(5);

    // Reset in the middle of the repeat phase, PB kept low across it
    do_press();
    step(LC + 3);
    #2 rst_n = 1'b0;
    #1 check("reset_async", outs, 5'b0);
    step(1);
    check("reset_hold", outs, 5'b0);
    step(2);
    rst_n = 1'b1;
    expect_for(DB + 1, ALL, 5'b0, "rst_press_wait");
    step(1);
    check("rst_press_edge", outs, P | H);
    expect_for(LC - 1, ALL, H, "rst_long_wait");
    step(1);
    check("rst_long_edge", outs, LG | H);
    do_release();
    step(5);

    // Single-sample debounce instance: pressed after E2, released three edges later
    pb1 = 1'b0;
    step(2);
    check("d1_wait", outs1, 5'b0);
    step(1);
    check("d1_press", outs1, P | H);
    pb1 = 1'b1;
    step(2);
    check("d1_held", outs1, H);
    step(1);
    check("d1_release", outs1, R);
    step(1);
    check("d1_idle", outs1, 5'b0);

    // Random button activity: glitches, short presses and long holds
    for (int b = 0; b < 60; b++) begin
      int r;
      int len;
      r   = int'($urandom_range(0, 9));
      len = (r < 3) ? int'($urandom_range(1, 7)) :
            (r < 7) ? int'($urandom_range(8, 20)) : int'($urandom_range(30, 90));
      pb = ~pb;
      step(len);
    end
    pb = 1'b1;
    step(30);
    check("final_idle", outs, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
